// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module : alu_seq_pkg
// Brief  : Shared op codes, FSM state type and helpers for alu_nibble_seq.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    function automatic logic is_arith(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_4bit.sv
// ============================================================================
// Module : alu_4bit
// Brief  : 4-bit ALU, no carry-in. o_carry is carry-out on add, borrow on sub.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_4bit
    import alu_seq_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [1:0] i_op,
    output logic [3:0] o_y,
    output logic       o_carry
);

    logic [4:0] w_sum;

    always_comb begin
        w_sum = 5'd0;
        case (i_op)
            OP_ADD:  w_sum = {1'b0, i_a} + {1'b0, i_b};
            OP_SUB:  w_sum = {1'b0, i_a} - {1'b0, i_b};
            OP_AND:  w_sum = {1'b0, i_a & i_b};
            default: w_sum = {1'b0, i_a | i_b};
        endcase
    end

    assign o_y     = w_sum[3:0];
    assign o_carry = w_sum[4];

endmodule

`default_nettype wire

// File: rtl/alu_nibble_seq.sv
// ============================================================================
// Module : alu_nibble_seq
// Brief  : WIDTH-bit add/sub/and/or sequenced one nibble per cycle on alu_4bit,
//          with a +/-1 correction pass when a carry/borrow enters a nibble.
//          Optional: `define ALU_SEQ_STATS_EN adds op_count / fix_count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_nibble_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
`ifdef ALU_SEQ_STATS_EN
    output logic [15:0]      op_count,
    output logic [15:0]      fix_count,
`endif
    output logic             carry
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NIB - 1);

    generate
        if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("alu_nibble_seq: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    seq_state_t       r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_cin;
    logic             r_cmain;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_out_valid;

    logic [IDX_W+1:0] w_base;
    logic [3:0]       w_alu_a;
    logic [3:0]       w_alu_b;
    logic [3:0]       w_alu_y;
    logic             w_alu_c;
    logic             w_need_fix;
    logic             w_advance;
    logic             w_next_cin;
    logic [WIDTH-1:0] w_next_acc;

    assign w_base = {r_idx, 2'b00};

    // FIX re-runs the stored nibble through the ALU with op_l and operand 1.
    always_comb begin
        w_alu_a = r_a[w_base +: 4];
        w_alu_b = r_b[w_base +: 4];
        if (r_state == FIX) begin
            w_alu_a = r_acc[w_base +: 4];
            w_alu_b = 4'b0001;
        end
    end

    alu_4bit u_alu (
        .i_a     (w_alu_a),
        .i_b     (w_alu_b),
        .i_op    (r_op),
        .o_y     (w_alu_y),
        .o_carry (w_alu_c)
    );

    always_comb begin
        w_next_acc = r_acc;
        for (int k = 0; k < NIB; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_next_acc[4*k +: 4] = w_alu_y;
            end
        end
    end

    assign w_need_fix = (r_state == EXEC) && is_arith(r_op) && r_cin;
    assign w_advance  = ((r_state == EXEC) && !w_need_fix) || (r_state == FIX);
    assign w_next_cin = (r_state == FIX) ? (r_cmain | w_alu_c) : w_alu_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_cin       <= 1'b0;
            r_cmain     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_ADD;
            r_acc       <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_idx   <= '0;
                        r_cin   <= 1'b0;
                        r_acc   <= '0;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_acc   <= w_next_acc;
                    r_cmain <= w_alu_c;
                    if (w_need_fix) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_acc <= w_next_acc;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_advance) begin
                r_cin <= w_next_cin;
                if (r_idx == c_LAST) begin
                    r_state     <= DONE;
                    r_result    <= w_next_acc;
                    r_zero      <= (w_next_acc == '0);
                    r_carry     <= is_arith(r_op) & w_next_cin;
                    r_out_valid <= 1'b1;
                end else begin
                    r_idx   <= r_idx + IDX_W'(1);
                    r_state <= EXEC;
                end
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] r_op_count;
    logic [15:0] r_fix_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count  <= 16'd0;
            r_fix_count <= 16'd0;
        end else begin
            if ((r_state == DONE) && out_ready && (r_op_count != 16'hFFFF)) begin
                r_op_count <= r_op_count + 16'd1;
            end
            if ((r_state == FIX) && (r_fix_count != 16'hFFFF)) begin
                r_fix_count <= r_fix_count + 16'd1;
            end
        end
    end

    assign op_count  = r_op_count;
    assign fix_count = r_fix_count;
`endif

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign carry     = r_carry;

endmodule

`default_nettype wire
